// File: rtl/minmax_tracker_4b.sv
// Windowed min/max tracker: accepts WINDOW 4-bit samples under valid/ready and
// reports the running/final extremes, sample count and a one-cycle done pulse.

module magcomp_4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       gto,
  output logic       lto,
  output logic       eqo
);
  assign gto = a > b;
  assign lto = a < b;
  assign eqo = a == b;
endmodule

module minmax_tracker_4b #(
  parameter int unsigned WINDOW = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [3:0] num,
  output logic       in_ready,
  output logic [3:0] maxo,
  output logic [3:0] mino,
  output logic [7:0] cnt,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] LAST = 8'(WINDOW - 1);

  state_t state;
  logic   max_gt, max_lt, max_eq;
  logic   min_gt, min_lt, min_eq;
  logic   cmp_unused;

  magcomp_4b u_cmp_max (
    .a   (num),
    .b   (maxo),
    .gto (max_gt),
    .lto (max_lt),
    .eqo (max_eq)
  );

  magcomp_4b u_cmp_min (
    .a   (num),
    .b   (mino),
    .gto (min_gt),
    .lto (min_lt),
    .eqo (min_eq)
  );

  assign cmp_unused = ^{max_lt, max_eq, min_gt, min_eq};

  // busy/in_ready/done are registered alongside state so they track the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      maxo     <= '0;
      mino     <= '1;
      cnt      <= '0;
      busy     <= 1'b0;
      in_ready <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= TRACK;
            maxo     <= '0;
            mino     <= '1;
            cnt      <= '0;
            busy     <= 1'b1;
            in_ready <= 1'b1;
          end else begin
            state    <= IDLE;
            busy     <= 1'b0;
            in_ready <= 1'b0;
          end
        end
        TRACK: begin
          if (in_valid) begin
            if (max_gt) maxo <= num;
            if (min_lt) mino <= num;
            cnt <= cnt + 8'd1;
            if (cnt == LAST) begin
              state    <= DONE;
              busy     <= 1'b0;
              in_ready <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_minmax_tracker_4b.sv
// Directed bench for minmax_tracker_4b with WINDOW = 8, 4 and 1 instances.

module tb_minmax_tracker_4b;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] num = '0;
  logic       start8 = 1'b0, start4 = 1'b0, start1 = 1'b0;

  logic       ready8, busy8, done8;
  logic [3:0] max8, min8;
  logic [7:0] cnt8;
  logic       ready4, busy4, done4;
  logic [3:0] max4, min4;
  logic [7:0] cnt4;
  logic       ready1, busy1, done1;
  logic [3:0] max1, min1;
  logic [7:0] cnt1;

  int checks = 0;
  int errors = 0;
  int cyc;

  always #5 clk = ~clk;

  minmax_tracker_4b #(.WINDOW(8)) u_w8 (
    .clk(clk), .rst(rst), .start(start8), .in_valid(in_valid), .num(num),
    .in_ready(ready8), .maxo(max8), .mino(min8), .cnt(cnt8), .busy(busy8), .done(done8)
  );

  minmax_tracker_4b #(.WINDOW(4)) u_w4 (
    .clk(clk), .rst(rst), .start(start4), .in_valid(in_valid), .num(num),
    .in_ready(ready4), .maxo(max4), .mino(min4), .cnt(cnt4), .busy(busy4), .done(done4)
  );

  minmax_tracker_4b #(.WINDOW(1)) u_w1 (
    .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid), .num(num),
    .in_ready(ready1), .maxo(max1), .mino(min1), .cnt(cnt1), .busy(busy1), .done(done1)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic feed(input logic [3:0] v);
    in_valid = 1'b1;
    num = v;
    tick();
  endtask

  logic [3:0] basic [8] = '{4'h5, 4'h3, 4'h9, 4'h9, 4'h0, 4'hF, 4'h7, 4'h2};
  logic [3:0] ign   [8] = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h2, 4'h2, 4'h2, 4'h2};

  initial begin
    // Power-on reset
    #2 rst = 1'b1;
    #1;
    check("por_max", max8, 8'h0);
    check("por_min", min8, 8'hF);
    check("por_cnt", cnt8, 8'd0);
    check("por_busy", busy8, 1'b0);
    check("por_done", done8, 1'b0);
    check("por_ready", ready8, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Basic window, WINDOW=8
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check("b_busy", busy8, 1'b1);
    check("b_ready", ready8, 1'b1);
    check("b_init_min", min8, 8'hF);
    for (int i = 0; i < 8; i++) begin
      feed(basic[i]);
      if (i == 2) begin
        check("b_mid_max", max8, 8'h9);
        check("b_mid_min", min8, 8'h3);
        check("b_mid_cnt", cnt8, 8'd3);
      end
      if (i < 7) check("b_nodone", done8, 1'b0);
    end
    in_valid = 1'b0;
    check("b_done", done8, 1'b1);
    check("b_max", max8, 8'hF);
    check("b_min", min8, 8'h0);
    check("b_cnt", cnt8, 8'd8);
    check("b_busy_done", busy8, 1'b0);
    check("b_ready_done", ready8, 1'b0);
    tick();
    check("b_done_pulse", done8, 1'b0);
    check("b_hold_cnt", cnt8, 8'd8);

    // in_valid in IDLE ignored
    feed(4'h3);
    feed(4'h3);
    check("i_idle_cnt", cnt8, 8'd8);
    check("i_idle_busy", busy8, 1'b0);
    in_valid = 1'b0;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check("i_restart_cnt", cnt8, 8'd0);
    for (int i = 0; i < 8; i++) begin
      start8 = (i == 3);
      feed(ign[i]);
    end
    start8 = 1'b0;
    check("i_done", done8, 1'b1);
    check("i_cnt", cnt8, 8'd8);
    check("i_max", max8, 8'h4);
    check("i_min", min8, 8'h2);
    // sample offered during DONE must be dropped
    in_valid = 1'b1;
    num = 4'hF;
    tick();
    in_valid = 1'b0;
    check("i_done_drop_max", max8, 8'h4);
    check("i_done_drop_cnt", cnt8, 8'd8);
    check("i_after_busy", busy8, 1'b0);
    check("i_after_done", done8, 1'b0);

    // Mid-window asynchronous reset
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    feed(4'h5);
    feed(4'hA);
    feed(4'h7);
    in_valid = 1'b0;
    check("r_pre_cnt", cnt8, 8'd3);
    check("r_pre_max", max8, 8'hA);
    #1 rst = 1'b1;
    #1;
    check("r_max", max8, 8'h0);
    check("r_min", min8, 8'hF);
    check("r_cnt", cnt8, 8'd0);
    check("r_busy", busy8, 1'b0);
    check("r_done", done8, 1'b0);
    check("r_ready", ready8, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    feed(4'h9);
    in_valid = 1'b0;
    check("r_idle_cnt", cnt8, 8'd0);
    check("r_idle_busy", busy8, 1'b0);

    // Bubbles and equality, WINDOW=4
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      feed(4'h6);
      in_valid = 1'b0;
      check("e_cnt", cnt4, 8'(i + 1));
      if (i < 3) begin
        check("e_nodone", done4, 1'b0);
        tick();
        check("e_bubble_cnt", cnt4, 8'(i + 1));
      end
    end
    check("e_done", done4, 1'b1);
    check("e_max", max4, 8'h6);
    check("e_min", min4, 8'h6);
    tick();
    check("e_done_pulse", done4, 1'b0);

    // Back-to-back windows, start held high
    start4 = 1'b1;
    tick();
    feed(4'h1);
    feed(4'h2);
    feed(4'h3);
    feed(4'h4);
    in_valid = 1'b0;
    check("k1_done", done4, 1'b1);
    check("k1_max", max4, 8'h4);
    check("k1_min", min4, 8'h1);
    cyc = 0;
    tick();
    cyc++;
    check("k_direct_busy", busy4, 1'b1);
    check("k_direct_cnt", cnt4, 8'd0);
    check("k_direct_min", min4, 8'hF);
    for (int i = 0; i < 4; i++) begin
      feed(4'h8);
      cyc++;
    end
    in_valid = 1'b0;
    check("k2_done", done4, 1'b1);
    check("k2_max", max4, 8'h8);
    check("k2_min", min4, 8'h8);
    check("k_period", 8'(cyc), 8'd5);
    start4 = 1'b0;
    tick();
    check("k_idle_busy", busy4, 1'b0);

    // Edge window, WINDOW=1
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("w1_busy", busy1, 1'b1);
    feed(4'h0);
    in_valid = 1'b0;
    check("w1_done", done1, 1'b1);
    check("w1_max", max1, 8'h0);
    check("w1_min", min1, 8'h0);
    check("w1_cnt", cnt1, 8'd1);
    tick();
    check("w1_done_pulse", done1, 1'b0);
    check("w1_hold_cnt", cnt1, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
